niosii_pio_out_blink: RTL and testbench
=======================================

# niosii_pio_out_blink

Parametrised Avalon-MM output PIO for the Nios II system, successor to the fixed 8-bit LED PIO. Drives `WIDTH` output pins from a data register, adds atomic set/clear/toggle ports, and adds a per-bit hardware blink mode driven by a programmable prescaler. Sits on the Nios II data master interconnect as a zero-wait-state slave; `out_port` goes to board LEDs or GPIO.

## Interface
- `WIDTH`, 8: number of output bits, 1..32.
- `RESET_VALUE`, 0: value of DATA after reset, `WIDTH` bits.
- `PERIOD_W`, 24: width of the PERIOD register, 1..32.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  word address of the register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; combinational from `address`, zero-extended.
- `out_port`  out  `WIDTH`  pin outputs.

## Operation
- Register map, by word address:
  - 0 DATA (rw): `WIDTH` bits.
  - 1 BLINK_EN (rw): per-bit blink mask, `WIDTH` bits.
  - 2 PERIOD (rw): prescaler reload, `PERIOD_W` bits.
  - 3 STATUS (ro): bit0 = phase.
  - 4 OUTSET (wo): DATA |= wd.
  - 5 OUTCLEAR (wo): DATA &= ~wd.
  - 6 TOGGLE (wo): DATA ^= wd.
  - 7: reserved.
- Reads of addresses 4–7 return 0. Writes to 3 and 7 are ignored. Upper `writedata` bits beyond the register width are ignored.
- Prescaler:
  - `count` decrements each cycle.
  - When `count==0` and `PERIOD!=0`, `phase` toggles and `count` reloads with PERIOD.
  - With PERIOD=N≥1, `phase` toggles every N+1 cycles.
  - PERIOD=0: `count` is held at 0, `phase` is held at 1 (blink frozen on).
- Output: `out_port = DATA & (~BLINK_EN | {WIDTH{phase}})`. Non-blink bits follow DATA; blink bits show DATA gated by `phase`.
- A write to PERIOD loads `count` with the new value and forces `phase=1` in the same edge. This write overrides a same-cycle expiry.
- Writes to DATA, BLINK_EN, OUTSET, OUTCLEAR and TOGGLE do not disturb `count` or `phase`.
- Reset values, all outputs included:
  - DATA=`RESET_VALUE`, BLINK_EN=0, PERIOD=0, `count`=0, `phase`=1.
  - `out_port`=`RESET_VALUE`, `readdata`=DATA at address 0.
- Reset asserted mid-blink returns every register to its reset value on the next edge. Reset has priority over a concurrent write.

## Timing
- Writes commit on the `clk` edge where the strobe is sampled. `out_port` reflects the write from that edge onward (zero added latency; all state is flopped, and `out_port` is a pure AND/OR of flops).
- Reads have zero wait states. `readdata` is valid in the same cycle as `address`.
- Only one access per cycle is possible, so register-vs-register write conflicts cannot occur. The only simultaneous event is a PERIOD write coinciding with prescaler expiry, which is resolved above.
- `phase` change appears on `out_port` in the cycle after the expiry edge.

## Structure
- Package `niosii_pio_pkg`:
  - register address constants `ADDR_DATA`..`ADDR_TOGGLE`;
  - `STATUS_PHASE_BIT`;
  - default `PERIOD_W`.
- Sub-module `niosii_pio_blink_timer` (params `PERIOD_W`):
  - inputs `clk`, `reset`, `period`, `period_wr`;
  - output `phase`;
  - contains the down-counter and phase flop.
- Top level holds the register file, read mux and output gating.

## Test plan
- Reset with `RESET_VALUE=8'hA5` → `out_port=8'hA5`, reads: 0→0xA5, 1→0, 2→0, 3→1.
- Write DATA=0x0F, then OUTSET 0x30, OUTCLEAR 0x03, TOGGLE 0x81 → DATA reads 0xBD; `out_port=0xBD`; address 4 reads 0.
- DATA=0xFF, BLINK_EN=0x01, PERIOD=3:
  - `out_port` bit0 is 1 for 4 cycles, 0 for 4 cycles, repeating;
  - bits 7:1 stay high;
  - STATUS bit0 tracks bit0.
- PERIOD write landing on the expiry cycle → `phase` is 1 after that edge and the next toggle occurs 4 cycles later (PERIOD=3). Writing PERIOD=0 freezes `phase` at 1.
- `reset` pulsed while blinking with `phase`=0 → next edge gives `out_port=RESET_VALUE`, PERIOD=0, no further toggling.
- `WIDTH=32`, `PERIOD_W=32`: write 0xFFFF_FFFF to DATA and PERIOD → both read back 0xFFFF_FFFF. With `WIDTH=5`, DATA reads 0x1F.

Source files
------------

// File: rtl/niosii_pio_out_blink_pkg.sv
// Shared constants for the Nios II output PIO with blink support:
// register word addresses, STATUS bit position and the default prescaler width.
package niosii_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int DEFAULT_PERIOD_W = 24;

endpackage

// File: rtl/niosii_pio_out_blink_if.sv
// Avalon-MM slave bus bundle for the output PIO (zero-wait-state, no waitrequest).
interface niosii_pio_out_blink_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/niosii_pio_out_blink_timer.sv
// Blink prescaler: down-counter that toggles phase on expiry and reloads from period.
// A period write reloads the counter and forces phase high, winning over a same-cycle expiry.
module niosii_pio_blink_timer #(
    parameter int PERIOD_W = niosii_pio_pkg::DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase
);

    logic [PERIOD_W-1:0] r_count;
    logic                r_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_phase <= 1'b1;
        end else if (period_wr) begin
            r_count <= period;
            r_phase <= 1'b1;
        end else if (r_count == '0) begin
            // PERIOD=0 leaves count parked at zero and phase frozen
            if (period != '0) begin
                r_count <= period;
                r_phase <= ~r_phase;
            end
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/niosii_pio_out_blink.sv
// Parametrised Avalon-MM output PIO: DATA register with set/clear/toggle ports
// and per-bit hardware blink gated by a programmable prescaler phase.
module niosii_pio_out_blink #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PERIOD_W    = niosii_pio_pkg::DEFAULT_PERIOD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    niosii_pio_out_blink_if.slave  bus,
    output logic [WIDTH-1:0]       out_port
);

    import niosii_pio_pkg::*;

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_blink_en;
    logic [PERIOD_W-1:0] r_period;

    logic                w_wr;
    logic                w_period_wr;
    logic [WIDTH-1:0]    w_wd;
    logic [PERIOD_W-1:0] w_wd_period;
    logic [PERIOD_W-1:0] w_timer_period;
    logic                w_phase;
    logic [31:0]         w_readdata;

    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_period_wr = w_wr && (bus.address == ADDR_PERIOD);
    assign w_wd        = bus.writedata[WIDTH-1:0];
    assign w_wd_period = bus.writedata[PERIOD_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_blink_en <= '0;
            r_period   <= '0;
        end else if (w_wr) begin
            case (bus.address)
                ADDR_DATA:     r_data     <= w_wd;
                ADDR_BLINK_EN: r_blink_en <= w_wd;
                ADDR_PERIOD:   r_period   <= w_wd_period;
                ADDR_OUTSET:   r_data     <= r_data | w_wd;
                ADDR_OUTCLEAR: r_data     <= r_data & ~w_wd;
                ADDR_TOGGLE:   r_data     <= r_data ^ w_wd;
                default:       ;
            endcase
        end
    end

    // The timer loads the incoming value directly on a PERIOD write
    assign w_timer_period = w_period_wr ? w_wd_period : r_period;

    niosii_pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .period    (w_timer_period),
        .period_wr (w_period_wr),
        .phase     (w_phase)
    );

    always_comb begin
        w_readdata = '0;
        case (bus.address)
            ADDR_DATA:     w_readdata[WIDTH-1:0]        = r_data;
            ADDR_BLINK_EN: w_readdata[WIDTH-1:0]        = r_blink_en;
            ADDR_PERIOD:   w_readdata[PERIOD_W-1:0]     = r_period;
            ADDR_STATUS:   w_readdata[STATUS_PHASE_BIT] = w_phase;
            default:       w_readdata = '0;
        endcase
    end

    assign bus.readdata = w_readdata;
    assign out_port     = r_data & (~r_blink_en | {WIDTH{w_phase}});

endmodule

// File: tb/tb_niosii_pio_out_blink.sv
// Scoreboard bench for the output PIO: stimulus pushes expected out_port/readdata
// from a timing-level model, a negedge monitor pops and compares.
module tb_niosii_pio_out_blink;

    localparam logic [7:0] RV = 8'hA5;

    typedef struct {
        logic [7:0]  out;
        logic [31:0] rd;
        logic [2:0]  addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_aux = 1'b1;
    always #5 clk = ~clk;

    niosii_pio_out_blink_if m_if ();
    niosii_pio_out_blink_if a32_if ();
    niosii_pio_out_blink_if a5_if ();

    logic [7:0]  out8;
    logic [31:0] out32;
    logic [4:0]  out5;

    niosii_pio_out_blink #(.WIDTH(8), .RESET_VALUE(RV), .PERIOD_W(24)) dut (
        .clk(clk), .reset(rst), .bus(m_if.slave), .out_port(out8));
    niosii_pio_out_blink #(.WIDTH(32), .RESET_VALUE(32'h0), .PERIOD_W(32)) dut32 (
        .clk(clk), .reset(rst_aux), .bus(a32_if.slave), .out_port(out32));
    niosii_pio_out_blink #(.WIDTH(5), .RESET_VALUE(5'h0), .PERIOD_W(24)) dut5 (
        .clk(clk), .reset(rst_aux), .bus(a5_if.slave), .out_port(out5));

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    // Reference model: registers plus edges elapsed since the last period (re)start
    logic [7:0] m_data;
    logic [7:0] m_blink;
    longint     m_period;
    longint     m_e;
    bit         m_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic m_phase();
        if (m_period == 0) return 1'b1;
        return ((m_e / (m_period + 1)) % 2) == 0;
    endfunction

    function automatic exp_t m_expect(input logic [2:0] a);
        exp_t x;
        x.addr = a;
        x.out  = m_data & (~m_blink | {8{m_phase()}});
        case (a)
            3'd0:    x.rd = {24'h0, m_data};
            3'd1:    x.rd = {24'h0, m_blink};
            3'd2:    x.rd = m_period[31:0];
            3'd3:    x.rd = {31'h0, m_phase()};
            default: x.rd = 32'h0;
        endcase
        return x;
    endfunction

    task automatic drive(input bit r, input bit cs, input bit wn,
                         input logic [2:0] a, input logic [31:0] wd);
        rst = r;
        m_if.chipselect = cs;
        m_if.write_n    = wn;
        m_if.address    = a;
        m_if.writedata  = wd;
        if (m_valid) q.push_back(m_expect(a));
        @(posedge clk);
        if (r) begin
            m_data = RV; m_blink = 0; m_period = 0; m_e = 0;
        end else begin
            m_e++;
            if (cs && !wn) begin
                case (a)
                    3'd0: m_data = wd[7:0];
                    3'd1: m_blink = wd[7:0];
                    3'd2: begin m_period = longint'(wd[23:0]); m_e = 0; end
                    3'd4: m_data = m_data | wd[7:0];
                    3'd5: m_data = m_data & ~wd[7:0];
                    3'd6: m_data = m_data ^ wd[7:0];
                    default: ;
                endcase
            end
        end
        m_valid = 1;
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        drive(0, 1, 0, a, wd);
    endtask

    task automatic idle(input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1, a, 32'hDEAD_BEEF);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("out_port", {24'h0, out8}, {24'h0, x.out});
            chk($sformatf("readdata@%0d", x.addr), m_if.readdata, x.rd);
        end
    end

    task automatic aux_wr(input logic [2:0] a, input logic [31:0] wd);
        a32_if.chipselect = 1; a32_if.write_n = 0; a32_if.address = a; a32_if.writedata = wd;
        a5_if.chipselect  = 1; a5_if.write_n  = 0; a5_if.address  = a; a5_if.writedata  = wd;
        @(posedge clk); #1;
        a32_if.chipselect = 0; a32_if.write_n = 1;
        a5_if.chipselect  = 0; a5_if.write_n  = 1;
    endtask

    initial begin
        a32_if.chipselect = 0; a32_if.write_n = 1; a32_if.address = 0; a32_if.writedata = 0;
        a5_if.chipselect  = 0; a5_if.write_n  = 1; a5_if.address  = 0; a5_if.writedata  = 0;

        // Reset and reset-value reads
        drive(1, 0, 1, 3'd0, 0);
        drive(1, 1, 0, 3'd0, 32'h0000_0055);
        rst_aux = 0;
        for (int a = 0; a < 8; a++) idle(a[2:0], 1);

        // Set/clear/toggle ports
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'hFFFF_FF30);
        wr(3'd5, 32'h03);
        wr(3'd6, 32'h81);
        idle(3'd0, 1);
        idle(3'd4, 1);
        wr(3'd3, 32'h0);
        wr(3'd7, 32'hFF);
        idle(3'd0, 1);

        // Blink bit0 with PERIOD=3
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h3);
        idle(3'd3, 12);

        // PERIOD write coinciding with expiry, then freeze with PERIOD=0
        wr(3'd2, 32'h3);
        idle(3'd3, 3);
        wr(3'd2, 32'h3);
        idle(3'd3, 10);
        wr(3'd2, 32'h0);
        idle(3'd3, 6);

        // Reset pulsed while phase is low
        wr(3'd2, 32'h3);
        idle(3'd3, 4);
        drive(1, 1, 0, 3'd3, 32'h1);
        idle(3'd2, 1);
        idle(3'd3, 6);
        idle(3'd0, 1);

        // Wide and narrow instances
        aux_wr(3'd0, 32'hFFFF_FFFF);
        aux_wr(3'd2, 32'hFFFF_FFFF);
        a32_if.address = 3'd0; a5_if.address = 3'd0; #1;
        chk("w32_data", a32_if.readdata, 32'hFFFF_FFFF);
        chk("w32_out", out32, 32'hFFFF_FFFF);
        chk("w5_data", a5_if.readdata, 32'h0000_001F);
        a32_if.address = 3'd2; a5_if.address = 3'd2; #1;
        chk("w32_period", a32_if.readdata, 32'hFFFF_FFFF);
        chk("w5_period", a5_if.readdata, 32'h00FF_FFFF);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2) wd = (wd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0)
                drive(1, $urandom_range(0, 1) == 1, 0, a, wd);
            else if ($urandom_range(0, 3) == 0)
                wr(a, wd);
            else
                idle(a, 1);
        end

        idle(3'd0, 1);
        @(negedge clk); #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
